// File: rtl/prog_launch.sv
// Launch sequencer: fires NPROG programs one after another, times each run and
// reports its cycle count, or a timeout, before moving on.
module prog_launch #(
  parameter int NPROG   = 3,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 4,
  parameter int TMO     = 1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic        Done,
  output logic        Start,
  output logic [1:0]  ProgIdx,
  output logic        Busy,
  output logic [15:0] Result,
  output logic        ResultValid,
  output logic        ResultTmo,
  output logic        AllDone
);

  localparam int PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int GCW = (GAP_W > 1) ? $clog2(GAP_W) : 1;
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_W - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(GAP_W - 1);
  localparam logic [15:0]    TMO_LAST   = 16'(TMO - 1);
  localparam logic [15:0]    TMO_VAL    = 16'(TMO);
  localparam logic [1:0]     LAST_IDX   = 2'(NPROG);

  typedef enum logic [2:0] {IDLE, PULSE, ARM, RUN, GAP, FINISH} state_t;

  state_t           state_reg;
  logic [PCW-1:0]   pulse_cnt_reg;
  logic [GCW-1:0]   gap_cnt_reg;
  logic [15:0]      cyc_count_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      cyc_count_reg <= '0;
      Start         <= 1'b0;
      ProgIdx       <= 2'd0;
      Busy          <= 1'b0;
      Result        <= 16'd0;
      ResultValid   <= 1'b0;
      ResultTmo     <= 1'b0;
      AllDone       <= 1'b0;
    end else begin
      ResultValid <= 1'b0;
      ResultTmo   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Go) begin
            state_reg     <= PULSE;
            ProgIdx       <= 2'd1;
            Start         <= 1'b1;
            Busy          <= 1'b1;
            pulse_cnt_reg <= '0;
          end
        end
        PULSE: begin
          if (pulse_cnt_reg == PULSE_LAST) begin
            state_reg     <= ARM;
            Start         <= 1'b0;
            cyc_count_reg <= 16'd0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
        end
        // ARM waits out a Done level left over from the previous program.
        ARM: begin
          if (cyc_count_reg == TMO_LAST) begin
            Result      <= TMO_VAL;
            ResultValid <= 1'b1;
            ResultTmo   <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else begin
            cyc_count_reg <= cyc_count_reg + 16'd1;
            if (!Done) state_reg <= RUN;
          end
        end
        // Completion is tested first so it beats a timeout on the same cycle.
        RUN: begin
          if (Done) begin
            Result      <= cyc_count_reg;
            ResultValid <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else if (cyc_count_reg == TMO_LAST) begin
            Result      <= TMO_VAL;
            ResultValid <= 1'b1;
            ResultTmo   <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else begin
            cyc_count_reg <= cyc_count_reg + 16'd1;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            if (ProgIdx < LAST_IDX) begin
              ProgIdx       <= ProgIdx + 2'd1;
              Start         <= 1'b1;
              pulse_cnt_reg <= '0;
              state_reg     <= PULSE;
            end else begin
              Busy      <= 1'b0;
              AllDone   <= 1'b1;
              state_reg <= FINISH;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        FINISH: ;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_launch.sv
// Bench for prog_launch: three instances (defaults, TMO=20, NPROG=1) driven by a
// small processor model, with expected results queued per instance.
module tb_prog_launch;

  logic             Clk;
  logic [2:0]       rst_s, go_s, done_s;
  logic [2:0]       start_s, busy_s, rv_s, tmo_s, ad_s;
  logic [2:0][1:0]  idx_s;
  logic [2:0][15:0] res_s;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int last_rv [3];
  bit prev_rv [3];
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];
  logic [16:0] q2 [$];

  prog_launch u_def (
    .Clk(Clk), .Reset(rst_s[0]), .Go(go_s[0]), .Done(done_s[0]),
    .Start(start_s[0]), .ProgIdx(idx_s[0]), .Busy(busy_s[0]), .Result(res_s[0]),
    .ResultValid(rv_s[0]), .ResultTmo(tmo_s[0]), .AllDone(ad_s[0]));

  prog_launch #(.TMO(20)) u_tmo (
    .Clk(Clk), .Reset(rst_s[1]), .Go(go_s[1]), .Done(done_s[1]),
    .Start(start_s[1]), .ProgIdx(idx_s[1]), .Busy(busy_s[1]), .Result(res_s[1]),
    .ResultValid(rv_s[1]), .ResultTmo(tmo_s[1]), .AllDone(ad_s[1]));

  prog_launch #(.NPROG(1)) u_one (
    .Clk(Clk), .Reset(rst_s[2]), .Go(go_s[2]), .Done(done_s[2]),
    .Start(start_s[2]), .ProgIdx(idx_s[2]), .Busy(busy_s[2]), .Result(res_s[2]),
    .ResultValid(rv_s[2]), .ResultTmo(tmo_s[2]), .AllDone(ad_s[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [16:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic push_exp(input int k, input logic tmo, input int res);
    logic [16:0] e;
    e = {tmo, res[15:0]};
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Scoreboard: every ResultValid strobe consumes one expected entry.
  always @(negedge Clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rv_s[k]) begin
        logic [16:0] e;
        $display("instance %0d result=%0d tmo=%0d", k, res_s[k], tmo_s[k]);
        check("rv_consec", 32'(prev_rv[k]), 0);
        if (qsize(k) == 0) begin
          check("unexpected_rv", 1, 0);
        end else begin
          e = qpop(k);
          check("result", 32'(res_s[k]), 32'(e[15:0]));
          check("result_tmo", 32'(tmo_s[k]), 32'(e[16]));
        end
        last_rv[k] = cyc_n;
      end
      prev_rv[k] = rv_s[k];
    end
  end

  task automatic wait_start(input int k, input logic lvl, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clk); #1;
      if (start_s[k] == lvl) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("wait_start", 0, 1);
  endtask

  // One launch: Done drops at the Start rise (hold<0) or hold cycles after the
  // Start fall, and rises dly cycles after the fall (dly<0: never).
  task automatic launch(input int k, input int idx, input int dly, input int hold,
                        input logic tmo, input int res, input bit chk_gap);
    bit ok;
    int w;
    int lim;
    push_exp(k, tmo, res);
    wait_start(k, 1'b1, ok);
    if (!ok) return;
    check("prog_idx", 32'(idx_s[k]), idx);
    if (chk_gap) check("gap_len", cyc_n - last_rv[k], 4);
    if (hold < 0) done_s[k] = 1'b0;
    w = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge Clk); #1;
      w++;
      if (!start_s[k]) break;
    end
    check("pulse_w", w, 2);
    check("busy_run", 32'(busy_s[k]), 1);
    lim = (dly > hold) ? dly : hold;
    for (int c = 1; c <= lim; c++) begin
      @(posedge Clk); #1;
      if (c == hold) done_s[k] = 1'b0;
      if (c == dly) done_s[k] = 1'b1;
    end
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 400; i++) begin
      @(posedge Clk); #1;
      if (ad_s[k]) break;
    end
    check("all_done", 32'(ad_s[k]), 1);
    check("busy_finish", 32'(busy_s[k]), 0);
    check("queue_empty", qsize(k), 0);
  endtask

  initial begin
    bit ok;
    int rises;
    logic prev_st;
    rst_s  = 3'b000;
    go_s   = 3'b000;
    done_s = 3'b000;
    #12;
    for (int k = 0; k < 3; k++) begin
      check("rst_start", 32'(start_s[k]), 0);
      check("rst_idx", 32'(idx_s[k]), 0);
      check("rst_busy", 32'(busy_s[k]), 0);
      check("rst_result", 32'(res_s[k]), 0);
      check("rst_rv", 32'(rv_s[k]), 0);
      check("rst_tmo", 32'(tmo_s[k]), 0);
      check("rst_alldone", 32'(ad_s[k]), 0);
    end
    @(posedge Clk); #1;
    rst_s = 3'b111;

    // Nominal three-program sequence.
    go_s[0] = 1'b1;
    launch(0, 1, 10, -1, 1'b0, 10, 1'b0);
    launch(0, 2, 10, -1, 1'b0, 10, 1'b0);
    launch(0, 3, 10, -1, 1'b0, 10, 1'b0);
    wait_done(0);

    // Stale Done held into program 2 for three cycles past the Start fall.
    rst_s[0] = 1'b0;
    @(posedge Clk); #1;
    rst_s[0] = 1'b1;
    launch(0, 1, 10, -1, 1'b0, 10, 1'b0);
    launch(0, 2, 10, 3, 1'b0, 10, 1'b0);
    launch(0, 3, 10, -1, 1'b0, 10, 1'b0);
    wait_done(0);

    // Asynchronous reset in the middle of program 2.
    rst_s[0] = 1'b0;
    @(posedge Clk); #1;
    rst_s[0] = 1'b1;
    launch(0, 1, 10, -1, 1'b0, 10, 1'b0);
    wait_start(0, 1'b1, ok);
    done_s[0] = 1'b0;
    wait_start(0, 1'b0, ok);
    repeat (5) @(posedge Clk);
    #2 rst_s[0] = 1'b0;
    #1;
    check("mid_rst_start", 32'(start_s[0]), 0);
    check("mid_rst_idx", 32'(idx_s[0]), 0);
    check("mid_rst_busy", 32'(busy_s[0]), 0);
    check("mid_rst_result", 32'(res_s[0]), 0);
    @(posedge Clk); #1;
    go_s[0]  = 1'b0;
    rst_s[0] = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("idle_start", 32'(start_s[0]), 0);
    check("idle_busy", 32'(busy_s[0]), 0);
    check("idle_idx", 32'(idx_s[0]), 0);
    go_s[0] = 1'b1;
    launch(0, 1, 10, -1, 1'b0, 10, 1'b0);
    launch(0, 2, 7, -1, 1'b0, 7, 1'b0);
    launch(0, 3, 12, -1, 1'b0, 12, 1'b0);
    wait_done(0);

    // TMO=20: timeouts and the Done-at-last-count tie.
    go_s[1] = 1'b1;
    launch(1, 1, -1, -1, 1'b1, 20, 1'b0);
    launch(1, 2, 19, -1, 1'b0, 19, 1'b1);
    launch(1, 3, -1, -1, 1'b1, 20, 1'b1);
    wait_done(1);

    // NPROG=1 with Go held after completion.
    go_s[2] = 1'b1;
    launch(2, 1, 10, -1, 1'b0, 10, 1'b0);
    wait_done(2);
    rises   = 0;
    prev_st = start_s[2];
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (start_s[2] && !prev_st) rises++;
      prev_st = start_s[2];
    end
    check("extra_start", rises, 0);
    check("finish_hold", 32'(ad_s[2]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
